// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state type and default sizing for the memory backend.
package mem_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  localparam int DEF_DEPTH = 256;
  localparam int DEF_LATENCY = 4;
endpackage

// File: rtl/mem_storage.sv
// mem_storage: word array with one synchronous write port and one combinational read port.
module mem_storage #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mem_backend.sv
// mem_backend: fixed-latency single-outstanding write-back/refill memory model
// with out-of-range detection.
module mem_backend
  import mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        mem_ready,
  output logic [31:0] rdata,
  output logic        addr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr_q, wr_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0] rd_word, resp_data;
  logic oor, we;
  assign oor = |(addr_q >> (AW + 2));
  assign resp_data = (wr_q || oor) ? '0 : rd_word;
  assign req_ready = state_q == S_IDLE;
  assign mem_ready = state_q == S_RESP;
  assign addr_err = mem_ready && oor;
  assign rdata = mem_ready ? resp_data : rdata_q;
  // the commit is gated by rst so a reset landing on the response edge aborts it
  assign we = mem_ready && wr_q && !oor && rst;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        wr_d = req_write;
        addr_d = req_addr;
        wdata_d = req_wdata;
        cnt_d = CW'(LATENCY - 1);
        state_d = LATENCY == 1 ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? S_RESP : S_WAIT;
      end
      default: begin
        rdata_d = resp_data;
        state_d = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  mem_storage #(.DEPTH(DEPTH)) u_storage (
    .clk(clk),
    .we_i(we),
    .waddr_i(addr_q[AW+1:2]),
    .wdata_i(wdata_q),
    .raddr_i(addr_q[AW+1:2]),
    .rdata_o(rd_word)
  );
endmodule
